// File: rtl/mash_pkg.sv
// Shared definitions for the MASH 1-1 modulator.
// - WIDTH_DEF / DAC_BW_DEF : default accumulator and output code widths.
// - code_t                 : signed output code at the default width.
// - CODE_MIN / CODE_MAX    : the full range of codes the modulator can emit.
package mash_pkg;

    localparam int unsigned WIDTH_DEF  = 16;
    localparam int unsigned DAC_BW_DEF = 4;

    typedef logic signed [DAC_BW_DEF-1:0] code_t;

    localparam code_t CODE_MIN = code_t'(-1);
    localparam code_t CODE_MAX = code_t'(2);

endpackage

// File: rtl/mash_stage.sv
// First-order error-feedback accumulator (one MASH stage).
// Ports:
//   aclk     in   clock
//   arst_n   in   asynchronous active-low reset, clears the accumulator
//   en       in   accumulate x on this edge
//   x        in   WIDTH-bit unsigned input
//   residue  out  WIDTH-bit wrapped sum acc + x (value acc takes when enabled)
//   carry    out  overflow bit of acc + x
import mash_pkg::*;

module mash_stage #(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] residue,
    output logic             carry
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum = {1'b0, acc} + {1'b0, x};
    end

    // Residue and carry are combinational so the next stage sees this
    // cycle's residue in the same edge.
    assign residue = sum[WIDTH-1:0];
    assign carry   = sum[WIDTH];

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mash_1_1.sv
// MASH 1-1 delta-sigma modulator: requantises an unsigned WIDTH-bit sample
// stream to a signed DAC_BW-bit code in -1..+2 with second-order shaped
// quantisation noise. Output mean equals x / 2^WIDTH.
// Ports:
//   aclk                in   clock
//   arst_n              in   asynchronous active-low reset
//   s_axis_data_tdata   in   WIDTH-bit unsigned sample
//   s_axis_data_tvalid  in   sample valid
//   s_axis_data_tready  out  0 in reset, 1 from the first edge after release
//   m_axis_data_tdata   out  signed output code (registered)
//   m_axis_data_tvalid  out  output valid (one-cycle delayed input valid)
import mash_pkg::*;

module mash_1_1 #(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DAC_BW = DAC_BW_DEF
) (
    input  logic              aclk,
    input  logic              arst_n,
    input  logic [WIDTH-1:0]  s_axis_data_tdata,
    input  logic              s_axis_data_tvalid,
    output logic              s_axis_data_tready,
    output logic [DAC_BW-1:0] m_axis_data_tdata,
    output logic              m_axis_data_tvalid
);

    logic              ready;
    logic              xfer;
    logic [WIDTH-1:0]  res1;
    logic [WIDTH-1:0]  res2;
    logic              c1;
    logic              c2;
    logic              c1_d;
    logic              c2_d;
    logic [DAC_BW-1:0] code_next;

    // A sample only moves through the pipe once ready is up, so the edge
    // that raises ready never produces a stray valid output.
    assign xfer               = s_axis_data_tvalid & ready;
    assign s_axis_data_tready = ready;

    mash_stage #(.WIDTH(WIDTH)) u_stage1 (
        .aclk    (aclk),
        .arst_n  (arst_n),
        .en      (xfer),
        .x       (s_axis_data_tdata),
        .residue (res1),
        .carry   (c1)
    );

    mash_stage #(.WIDTH(WIDTH)) u_stage2 (
        .aclk    (aclk),
        .arst_n  (arst_n),
        .en      (xfer),
        .x       (res1),
        .residue (res2),
        .carry   (c2)
    );

    // Noise cancellation: c1_d + c2 - c2_d. Done modulo 2^DAC_BW on
    // zero-extended carries, which yields the correct two's complement code.
    always_comb begin
        code_next = {{(DAC_BW-1){1'b0}}, c1_d}
                  + {{(DAC_BW-1){1'b0}}, c2}
                  - {{(DAC_BW-1){1'b0}}, c2_d};
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            ready              <= 1'b0;
            c1_d               <= 1'b0;
            c2_d               <= 1'b0;
            m_axis_data_tdata  <= '0;
            m_axis_data_tvalid <= 1'b0;
        end else begin
            ready              <= 1'b1;
            m_axis_data_tvalid <= xfer;
            if (xfer) begin
                c1_d              <= c1;
                c2_d              <= c2;
                m_axis_data_tdata <= code_next;
            end
        end
    end

    logic unused;
    assign unused = ^res2;

endmodule

// File: tb/tb_mash_1_1.sv
module tb_mash_1_1;

    localparam int W   = 16;
    localparam int DBW = 4;

    logic           aclk   = 1'b0;
    logic           arst_n = 1'b0;
    logic [W-1:0]   s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [DBW-1:0] m_data;
    logic           m_valid;

    mash_1_1 #(.WIDTH(W), .DAC_BW(DBW)) dut (
        .aclk               (aclk),
        .arst_n             (arst_n),
        .s_axis_data_tdata  (s_data),
        .s_axis_data_tvalid (s_valid),
        .s_axis_data_tready (s_ready),
        .m_axis_data_tdata  (m_data),
        .m_axis_data_tvalid (m_valid)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: two modulo-2^W accumulators with carries computed by
    // integer division, and the cancellation combination of those carries.
    longint md_acc1, md_acc2;
    int     md_c1d, md_c2d, md_code, md_valid;

    typedef struct {
        logic       vin;
        logic [W-1:0] x;
        int         code;
        int         valid;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int code_of();
        return int'($signed(m_data));
    endfunction

    task automatic model_reset();
        md_acc1 = 0; md_acc2 = 0; md_c1d = 0; md_c2d = 0;
        md_code = 0; md_valid = 0;
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] x);
        longint s1, s2;
        int c1, c2;
        md_valid = int'(v);
        if (v) begin
            s1 = md_acc1 + longint'(x);
            c1 = int'(s1 / 65536);
            md_acc1 = s1 % 65536;
            s2 = md_acc2 + md_acc1;
            c2 = int'(s2 / 65536);
            md_acc2 = s2 % 65536;
            md_code = md_c1d + c2 - md_c2d;
            md_c1d = c1;
            md_c2d = c2;
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] x);
        s_valid = v;
        s_data  = x;
        @(posedge aclk);
        #1;
        model_step(v, x);
    endtask

    task automatic check_model(input string tag);
        int c;
        c = code_of();
        check({tag, "_code"}, c, md_code);
        check({tag, "_valid"}, int'(m_valid), md_valid);
        check({tag, "_range"}, int'(c >= -1 && c <= 2), 1);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_data  = '0;
        arst_n  = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge aclk);
            #1;
            check("rst_tdata", int'(m_data), 0);
            check("rst_mvalid", int'(m_valid), 0);
            check("rst_tready", int'(s_ready), 0);
        end
        arst_n = 1'b1;
        @(posedge aclk);
        #1;
        check("tready_after_release", int'(s_ready), 1);
        check("tdata_after_release", int'(m_data), 0);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].vin, tbl[i].x);
            check({tag, "_code"}, code_of(), tbl[i].code);
            check({tag, "_valid"}, int'(m_valid), tbl[i].valid);
        end
    endtask

    initial begin
        int hs[8] = '{0, 0, 2, -1, 1, 0, 2, -1};
        int tail[4] = '{1, 0, 2, -1};
        int win[4];
        longint fsum;
        longint phase;
        real    ang;
        int     xs[2048];
        int     ys[2048];

        // Half scale from reset, a 5-cycle stall, then resumption.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{vin: 1'b1, x: 16'h8000, code: hs[i], valid: 1};
        for (int i = 8; i < 13; i++)
            tbl[i] = '{vin: 1'b0, x: 16'h8000, code: -1, valid: 0};
        for (int i = 0; i < 4; i++)
            tbl[13 + i] = '{vin: 1'b1, x: 16'h8000, code: tail[i], valid: 1};

        do_reset();
        run_table("halfscale");

        // Continued half scale: every 4-output window sums to 2.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'h8000);
            check_model("half_cont");
            win[i % 4] = code_of();
            if (i >= 3) check("half_win4", win[0] + win[1] + win[2] + win[3], 2);
        end

        // Asynchronous reset mid-stream, then the stream restarts from zero.
        for (int i = 0; i < 7; i++) step(1'b1, 16'(($urandom_range(65535))));
        #2;
        arst_n = 1'b0;
        #1;
        check("async_rst_tdata", int'(m_data), 0);
        check("async_rst_mvalid", int'(m_valid), 0);
        check("async_rst_tready", int'(s_ready), 0);
        do_reset();
        run_table("restart");

        // DC zero.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 16'h0000);
            check("dc0_code", code_of(), 0);
            check("dc0_valid", int'(m_valid), 1);
        end

        // Random samples with random valid gaps.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(3) != 0), 16'($urandom_range(65535)));
            check_model("rand");
        end

        // Near full scale: running mean within 1/1024 of 0xFFFF/65536.
        do_reset();
        fsum = 0;
        for (int i = 0; i < 4096; i++) begin
            step(1'b1, 16'hFFFF);
            check_model("full");
            fsum += code_of();
        end
        begin
            longint err;
            err = fsum * 65536 - longint'(4096) * 65535;
            if (err < 0) err = -err;
            check("full_mean", int'(err * 1024 <= longint'(4096) * 65536), 1);
        end

        // NCO-style sine input, phase step 1<<22 on a 32-bit phase.
        do_reset();
        phase = 0;
        for (int n = 0; n < 2048; n++) begin
            ang = 6.283185307179586 * real'(phase) / 4294967296.0;
            xs[n] = int'(32768.0 + 32767.0 * $sin(ang));
            phase = (phase + (longint'(1) << 22)) % (longint'(1) << 32);
            step(1'b1, 16'(xs[n]));
            check_model("nco");
            ys[n] = code_of();
            if (n >= 32 && (n % 64) == 0) begin
                longint sy, sx, d;
                sy = 0; sx = 0;
                for (int k = 0; k < 32; k++) begin
                    sy += ys[n - k];
                    sx += xs[n - 1 - k];
                end
                d = sy * 65536 - sx;
                if (d < 0) d = -d;
                check("nco_avg32", int'(d < 2 * 65536), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
